// File: rtl/spi_slave_fifo_if.sv
// -----------------------------------------------------------------------------
// spi_slave_fifo_if
// Bundles the SPI header pins and the controller-side RX/TX/status signals of
// spi_slave_fifo.
//   master modport : host pins driven in, controller drives TX_data/TX_push/
//                    err_clr, and observes everything else.
//   slave  modport : the spi_slave_fifo side.
// Signals:
//   SPI_clock, SPI_cs_n, SPI_mosi : host SPI lines (asynchronous to clock)
//   SPI_miso                      : data to host, 1 while deselected
//   RX_data / RX_valid            : last complete received word / new-word pulse
//   TX_data / TX_push             : word to queue / enqueue strobe
//   TX_full / TX_level            : FIFO full flag / occupancy
//   TX_request                    : pulse when a word boundary loads the shifter
//   busy / frame_end              : chip select active / end-of-frame pulse
//   err / err_clr                 : sticky {overflow, underflow} / clear
// -----------------------------------------------------------------------------
interface spi_slave_fifo_if #(
   parameter int DATA_W   = 8,
   parameter int TX_DEPTH = 4
);
   logic                        SPI_clock;
   logic                        SPI_cs_n;
   logic                        SPI_mosi;
   logic                        SPI_miso;
   logic [DATA_W-1:0]           RX_data;
   logic                        RX_valid;
   logic [DATA_W-1:0]           TX_data;
   logic                        TX_push;
   logic                        TX_full;
   logic [$clog2(TX_DEPTH):0]   TX_level;
   logic                        TX_request;
   logic                        busy;
   logic                        frame_end;
   logic [1:0]                  err;
   logic                        err_clr;

   modport master (
      output SPI_clock, SPI_cs_n, SPI_mosi, TX_data, TX_push, err_clr,
      input  SPI_miso, RX_data, RX_valid, TX_full, TX_level, TX_request,
             busy, frame_end, err
   );

   modport slave (
      input  SPI_clock, SPI_cs_n, SPI_mosi, TX_data, TX_push, err_clr,
      output SPI_miso, RX_data, RX_valid, TX_full, TX_level, TX_request,
             busy, frame_end, err
   );
endinterface

// File: rtl/spi_slave_fifo.sv
// -----------------------------------------------------------------------------
// spi_slave_fifo
// SPI slave with configurable word width, CPOL/CPHA, bit order and a TX FIFO.
// The SPI lines are oversampled in the system clock domain through
// synchronisers; clock must run at least 8x SPI_clock.
// Ports:
//   clock   : system clock
//   reset_n : asynchronous active-low reset
//   bus     : spi_slave_fifo_if.slave (SPI pins, RX/TX words, FIFO status,
//             busy, frame_end, err/err_clr)
// Build option:
//   SPI_SLAVE_ERR_EN : when defined, err[0] (TX underflow) and err[1] (push
//                      while full) are sticky flags cleared by err_clr; when
//                      undefined err reads 0 and err_clr is ignored.
// -----------------------------------------------------------------------------
module spi_slave_fifo #(
   parameter int                DATA_W      = 8,
   parameter int                TX_DEPTH    = 4,
   parameter int                SYNC_STAGES = 2,
   parameter int                CPOL        = 0,
   parameter int                CPHA        = 0,
   parameter int                MSB_FIRST   = 1,
   parameter logic [DATA_W-1:0] IDLE_WORD   = '1
) (
   input  logic            clock,
   input  logic            reset_n,
   spi_slave_fifo_if.slave bus
);
   localparam int            AW          = $clog2(TX_DEPTH);
   localparam int            CW          = $clog2(DATA_W);
   localparam logic          CLK_IDLE    = (CPOL != 0);
   localparam logic          SAMPLE_RISE = (CPOL == CPHA);
   localparam logic [CW-1:0] LAST_BIT    = CW'(DATA_W - 1);
   localparam logic [AW:0]   FULL_LEVEL  = (AW+1)'(TX_DEPTH);

   // Position in the word of the cnt-th transferred bit.
   function automatic logic [CW-1:0] bit_index(input logic [CW-1:0] cnt);
      return (MSB_FIRST != 0) ? LAST_BIT - cnt : cnt;
   endfunction

   function automatic logic bit_of(input logic [DATA_W-1:0] word, input logic [CW-1:0] cnt);
      return word[bit_index(cnt)];
   endfunction

   function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] sr, input logic b);
      if (MSB_FIRST != 0) return {sr[DATA_W-2:0], b};
      else                return {b, sr[DATA_W-1:1]};
   endfunction

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t                  state, state_nxt;
   logic [SYNC_STAGES-1:0]  sclk_sync, cs_sync, mosi_sync;
   logic                    sclk_s, sclk_prev, cs_s, mosi_s;
   logic                    sclk_rise, sclk_fall, sample_edge, shift_edge;
   logic                    start, stop, do_sample, do_shift, word_done, do_load;
   logic [CW-1:0]           bit_cnt;
   logic [DATA_W-1:0]       rx_sr, rx_next, rx_data, tx_word, next_word;
   logic                    miso_p0, miso_p1;
   logic                    rx_valid, tx_request, frame_end;
   logic [DATA_W-1:0]       mem [TX_DEPTH];
   logic [AW-1:0]           wr_ptr, rd_ptr;
   logic [AW:0]             level;
   logic                    full, pop, push_ok;

   // ---- synchroniser stage: SPI lines into the clock domain ----
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sclk_sync <= {SYNC_STAGES{CLK_IDLE}};
         cs_sync   <= '1;
         mosi_sync <= '0;
         sclk_prev <= CLK_IDLE;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.SPI_clock};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.SPI_cs_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.SPI_mosi};
         sclk_prev <= sclk_s;
      end
   end

   assign sclk_s      = sclk_sync[SYNC_STAGES-1];
   assign cs_s        = cs_sync[SYNC_STAGES-1];
   assign mosi_s      = mosi_sync[SYNC_STAGES-1];
   assign sclk_rise   = sclk_s & ~sclk_prev;
   assign sclk_fall   = ~sclk_s & sclk_prev;
   assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
   assign shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;

   // ---- control stage: frame FSM ----
   // cs is level-tested: in IDLE the synchronised cs was high, so low means a fall.
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      stop      = 1'b0;
      do_sample = 1'b0;
      do_shift  = 1'b0;
      case (state)
         IDLE: begin
            if (!cs_s) begin
               state_nxt = ACTIVE;
               start     = 1'b1;
            end
         end
         ACTIVE: begin
            if (cs_s) begin
               state_nxt = IDLE;
               stop      = 1'b1;
            end else begin
               do_sample = sample_edge;
               do_shift  = shift_edge;
            end
         end
      endcase
   end

   assign word_done = do_sample && (bit_cnt == LAST_BIT);
   assign do_load   = start || word_done;
   assign rx_next   = shift_in(rx_sr, mosi_s);

   // TX FIFO: a pop frees the head slot in the same cycle, so push+pop is
   // accepted even when full.
   assign full      = (level == FULL_LEVEL);
   assign pop       = do_load && (level != '0);
   assign push_ok   = bus.TX_push && (!full || pop);
   assign next_word = pop ? mem[rd_ptr] : IDLE_WORD;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         miso_p0    <= 1'b1;
         miso_p1    <= 1'b1;
         rx_valid   <= 1'b0;
         tx_request <= 1'b0;
         frame_end  <= 1'b0;
         rx_data    <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
      end else begin
         state      <= state_nxt;
         rx_valid   <= word_done;
         // Only word-boundary loads request more data; the frame-start load
         // consumes a word that was queued ahead of the host.
         tx_request <= word_done;
         frame_end  <= stop;
         miso_p1    <= miso_p0;

         if (do_load)        bit_cnt <= '0;
         else if (do_sample) bit_cnt <= bit_cnt + 1'b1;

         if (word_done) rx_data <= rx_next;

         if (stop)          miso_p0 <= 1'b1;
         else if (start)    miso_p0 <= bit_of(next_word, '0);
         else if (do_shift) miso_p0 <= bit_of(tx_word, bit_cnt);

         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         if (push_ok && !pop)      level <= level + 1'b1;
         else if (pop && !push_ok) level <= level - 1'b1;
      end
   end

   // ---- data stage: shifters and FIFO storage ----
   always_ff @(posedge clock) begin
      if (start)          rx_sr <= '0;
      else if (do_sample) rx_sr <= rx_next;
      if (do_load) tx_word <= next_word;
      if (push_ok) mem[wr_ptr] <= bus.TX_data;
   end

`ifdef SPI_SLAVE_ERR_EN
   logic       underflow, overflow;
   logic [1:0] err_q;

   assign underflow = do_load && (level == '0);
   assign overflow  = bus.TX_push && full && !pop;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)         err_q <= '0;
      else if (bus.err_clr) err_q <= '0;
      else                  err_q <= err_q | {overflow, underflow};
   end

   assign bus.err = err_q;
`else
   logic unused_err_clr;
   assign unused_err_clr = bus.err_clr;
   assign bus.err        = 2'b00;
`endif

   assign bus.SPI_miso   = miso_p1;
   assign bus.RX_data    = rx_data;
   assign bus.RX_valid   = rx_valid;
   assign bus.TX_full    = full;
   assign bus.TX_level   = level;
   assign bus.TX_request = tx_request;
   assign bus.busy       = (state == ACTIVE);
   assign bus.frame_end  = frame_end;
endmodule

// File: doc/spi_slave_fifo.md
# spi_slave_fifo

Parametrised SPI slave that generalises the existing byte-wide TPM SPI slave: configurable word width, SPI mode (CPOL/CPHA), bit order and a TX FIFO, so the TPM SPI controller can queue response bytes ahead of the host clock. It sits between the SPI header pins and the TPM SPI controller, runs entirely in the system clock domain, and oversamples the SPI lines through synchronisers.

## Interface
- DATA_W, 8: bits per SPI word (4..32).
- TX_DEPTH, 4: TX FIFO entries; power of two, ≥2.
- SYNC_STAGES, 2: synchroniser flops on SPI_clock/SPI_cs_n/SPI_mosi; ≥2.
- CPOL, 0: SPI clock idle level.
- CPHA, 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- MSB_FIRST, 1: 1 = bit DATA_W-1 shifted first.
- IDLE_WORD, all ones: word shifted out on TX underflow.

- clock  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- SPI_clock  in  1  host SPI clock (asynchronous).
- SPI_cs_n  in  1  host chip select, active low.
- SPI_mosi  in  1  host data in.
- SPI_miso  out  1  data to host; 1 while deselected.
- RX_data  out  DATA_W  last complete received word; held until next.
- RX_valid  out  1  one-cycle pulse, RX_data new.
- TX_data  in  DATA_W  word to queue.
- TX_push  in  1  enqueue TX_data this cycle.
- TX_full  out  1  FIFO full.
- TX_level  out  $clog2(TX_DEPTH)+1  FIFO occupancy.
- TX_request  out  1  one-cycle pulse when a word is loaded into the shifter.
- busy  out  1  synchronised chip select asserted.
- frame_end  out  1  one-cycle pulse on synchronised cs deassertion.
- err  out  2  sticky: [0] TX underflow, [1] push while full.
- err_clr  in  1  clears err.

## Operation
- Synchronisers reset to SPI_clock=CPOL, SPI_cs_n=1, SPI_mosi=0; edges detected on last two synchronised clock samples.
- Sample edge = rising when CPOL==CPHA, else falling; shift edge is the opposite. Edges ignored while busy=0.
- States IDLE, ACTIVE. IDLE→ACTIVE on synced cs fall: bit_cnt=0, rx shifter cleared, next word loaded, SPI_miso = its first bit. ACTIVE→IDLE on synced cs rise: frame_end pulse, partial RX word discarded, loaded TX word discarded (not returned to FIFO), SPI_miso=1.
- Sample edge: shift synced mosi into RX shifter per MSB_FIRST; bit_cnt++. On bit_cnt reaching DATA_W: RX_data updated, RX_valid pulse, bit_cnt wraps to 0, next TX word loaded, TX_request pulse.
- Shift edge: SPI_miso <= bit bit_cnt (in bit order) of current TX word. Same rule covers CPHA=0 and CPHA=1.
- Word load: FIFO head popped if TX_level>0; else IDLE_WORD loaded, err[0] set.
- FIFO: push+pop same cycle allowed at any level (level unchanged, including when full). Push while full without pop: dropped, err[1] set. Pointers wrap modulo TX_DEPTH.
- err_clr has priority over a same-cycle set.

## Timing
- Requirement: clock frequency ≥ 8× SPI_clock.
- Physical edge → internal action: SYNC_STAGES+1 cycles; RX_valid/TX_request asserted the cycle after.
- Shift-edge → SPI_miso change: SYNC_STAGES+2 cycles.
- TX_full/TX_level update the cycle after push/pop.
- Reset values: SPI_miso=1, RX_data=0, RX_valid=0, TX_full=0, TX_level=0, TX_request=0, busy=0, frame_end=0, err=0; FIFO emptied, state IDLE. Reset mid-frame abandons the frame; no frame_end pulse.

## Configuration
- SPI_SLAVE_ERR_EN defined: err flags implemented as above.
- Undefined: err tied to 0, err_clr ignored, no error logic synthesised; all other behaviour identical.

## Test plan
- Mode 0, DATA_W=8: push 0xA5, host sends 0x3C → SPI_miso bits 1,0,1,0,0,1,0,1; RX_data=0x3C, one RX_valid, TX_level 1→0.
- Modes 1/2/3 each, 2-word frame, FIFO preloaded 0x12,0x34 → host reads 0x12,0x34; two TX_request pulses.
- Empty FIFO, 1-word frame → host reads 0xFF, err=2'b01 (macro on) / 2'b00 (macro off).
- Push 5 words, TX_DEPTH=4 → TX_full=1, TX_level=4, err[1]=1; err_clr → err=0.
- cs released after 5 bits → frame_end pulse, no RX_valid, SPI_miso=1; next frame starts at bit 0.
- reset_n low mid-frame with FIFO at 3 → all outputs at reset values, TX_level=0 immediately.
